// File: rtl/gray_frame_writer.sv
// Packs the luma byte of a {g,g,g} pixel stream into 32-bit words (4 pixels per word)
// and writes one frame of NUM_PIXELS pixels sequentially into an output sram.
module gray_frame_writer #(
    parameter int NUM_PIXELS = 600,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [23:0]           in_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CW = $clog2(NUM_PIXELS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state, state_next;
    logic [CW-1:0]         pixel_cnt;
    logic [ADDR_WIDTH-1:0] word_cnt;
    logic [1:0]            lane;
    logic [31:0]           pack, pack_merged;
    logic                  accept, last_pixel, issue, pixel_bad;

    assign in_ready   = (state == RUN);
    assign accept     = in_valid && in_ready;
    assign last_pixel = (pixel_cnt == CW'(NUM_PIXELS - 1));
    assign issue      = accept && (lane == 2'd3 || last_pixel);
    assign pixel_bad  = (in_data[23:16] != in_data[15:8]) || (in_data[15:8] != in_data[7:0]);

    // Current byte merged into the pack register so a write carries it on the same edge.
    always_comb begin
        pack_merged = pack;
        pack_merged[8*lane +: 8] = in_data[15:8];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = RUN;
            RUN:        if (accept && last_pixel) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_cnt <= '0;
            word_cnt  <= '0;
            lane      <= '0;
            pack      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (state != RUN && start) begin
                pixel_cnt <= '0;
                word_cnt  <= '0;
                lane      <= '0;
                pack      <= '0;
                busy      <= 1'b1;
                done      <= 1'b0;
                err       <= 1'b0;
            end else if (accept) begin
                pixel_cnt <= pixel_cnt + CW'(1);
                lane      <= lane + 2'd1;
                if (pixel_bad) err <= 1'b1;
                if (issue) begin
                    // Unfilled lanes of a final partial word stay 0 since pack was cleared.
                    mem_we    <= 1'b1;
                    mem_wdata <= pack_merged;
                    mem_addr  <= word_cnt;
                    word_cnt  <= word_cnt + ADDR_WIDTH'(1);
                    pack      <= '0;
                end else begin
                    pack <= pack_merged;
                end
                if (last_pixel) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gray_frame_writer.sv
// Scoreboard bench: a 600-pixel and a 6-pixel writer driven with random gaps;
// expected writes (cycle, address, word, done) are queued by the driver, popped by a monitor.
module tb_gray_frame_writer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start0, in_valid0, in_ready0, mem_we0, busy0, done0, err0;
    logic [23:0] in_data0;
    logic [7:0]  mem_addr0;
    logic [31:0] mem_wdata0;

    logic        start1, in_valid1, in_ready1, mem_we1, busy1, done1, err1;
    logic [23:0] in_data1;
    logic [1:0]  mem_addr1;
    logic [31:0] mem_wdata1;

    gray_frame_writer #(.NUM_PIXELS(600), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start0), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_data(in_data0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .busy(busy0), .done(done0), .err(err0));

    gray_frame_writer #(.NUM_PIXELS(6), .ADDR_WIDTH(2)) dut6 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .busy(busy1), .done(done1), .err(err1));

    typedef struct {
        int          cyc;
        int          addr;
        logic [31:0] data;
        bit          last;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    bit  mon_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_write(input bit sel, input int c, input int addr,
                               input logic [31:0] data, input logic dn);
        wr_t e;
        if ((sel ? q1.size() : q0.size()) == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write inst%0d: got addr %0d data %h at cycle %0d, expected none",
                     sel, addr, data, c);
            return;
        end
        if (sel) e = q1.pop_front();
        else     e = q0.pop_front();
        chk("write_cycle", 64'(c), 64'(e.cyc));
        chk("write_addr", 64'(addr), 64'(e.addr));
        chk("write_data", 64'(data), 64'(e.data));
        chk("done_at_write", 64'(dn), 64'(e.last));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_we0 === 1'b1) check_write(1'b0, cyc, int'(mem_addr0), mem_wdata0, done0);
            if (mem_we1 === 1'b1) check_write(1'b1, cyc, int'(mem_addr1), mem_wdata1, done1);
        end
    end

    task automatic set_in(input bit sel, input logic st, input logic v, input logic [23:0] d);
        if (sel) begin start1 = st; in_valid1 = v; in_data1 = d; end
        else     begin start0 = st; in_valid0 = v; in_data0 = d; end
    endtask

    function automatic logic [3:0] status(input bit sel);
        return sel ? {in_ready1, busy1, done1, err1} : {in_ready0, busy0, done0, err0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: pixel k lands in word k/4 at byte k%4; a word is due after lane 3 or the last pixel.
    task automatic run_frame(input bit sel, input bit gaps, input int stop_after, input int bad_idx);
        int          n;
        logic [31:0] acc;
        logic [7:0]  g;
        logic [23:0] px;
        wr_t         e;
        n   = sel ? 6 : 600;
        acc = '0;
        tick();
        set_in(sel, 1'b1, 1'b0, 24'($urandom));
        tick();
        set_in(sel, 1'b0, 1'b0, 24'($urandom));
        chk("status_after_start", 64'(status(sel)), 64'(4'b1100));
        for (int k = 0; k < stop_after; k++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    set_in(sel, 1'b0, 1'b0, 24'($urandom));
                    tick();
                end
            end
            g   = sel ? 8'(8'h11 * (k + 1)) : 8'(k % 256);
            px  = (k == bad_idx) ? 24'h102030 : {g, g, g};
            acc = acc | (32'(px[15:8]) << (8 * (k % 4)));
            set_in(sel, 1'b0, 1'b1, px);
            if (k % 4 == 3 || k == n - 1) begin
                e.cyc  = cyc + 1;
                e.addr = k / 4;
                e.data = acc;
                e.last = (k == n - 1);
                if (sel) q1.push_back(e);
                else     q0.push_back(e);
                acc = '0;
            end
            tick();
        end
        set_in(sel, 1'b0, 1'b0, 24'($urandom));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b1, 24'($urandom));
        set_in(1'b1, 1'b0, 1'b1, 24'($urandom));
        // start alongside rst must lose to rst
        repeat (3) begin
            tick();
            set_in(1'b0, 1'b1, 1'b1, 24'($urandom));
            set_in(1'b1, 1'b1, 1'b1, 24'($urandom));
            chk("rst_status0", 64'(status(1'b0)), 64'(0));
            chk("rst_mem0", 64'({mem_we0, mem_addr0, mem_wdata0}), 64'(0));
            chk("rst_status1", 64'(status(1'b1)), 64'(0));
        end
        set_in(1'b0, 1'b0, 1'b1, 24'($urandom));
        set_in(1'b1, 1'b0, 1'b1, 24'($urandom));
        rst = 1'b0;
        mon_en = 1;
        repeat (3) tick();
        chk("idle_after_rst", 64'(status(1'b0)), 64'(0));
        set_in(1'b1, 1'b0, 1'b0, 24'($urandom));

        // gap-free frame of k%256
        run_frame(1'b0, 1'b0, 600, -1);
        chk("frame_end_status", 64'(status(1'b0)), 64'(4'b0010));
        set_in(1'b0, 1'b0, 1'b1, 24'($urandom));
        repeat (5) tick();
        chk("done_sticky_ignores_pixels", 64'(status(1'b0)), 64'(4'b0010));
        set_in(1'b0, 1'b0, 0, 24'($urandom));

        // 6-pixel frame, partial last word
        run_frame(1'b1, 1'b0, 6, -1);
        chk("small_frame_end", 64'(status(1'b1)), 64'(4'b0010));
        run_frame(1'b1, 1'b1, 6, -1);
        chk("small_frame_gaps_end", 64'(status(1'b1)), 64'(4'b0010));

        // random in_valid gaps
        run_frame(1'b0, 1'b1, 600, -1);
        chk("gap_frame_end", 64'(status(1'b0)), 64'(4'b0010));

        // one non-gray pixel: err set and held
        run_frame(1'b0, 1'b1, 600, 100);
        chk("err_at_done", 64'(status(1'b0)), 64'(4'b0011));
        repeat (3) tick();
        chk("err_held", 64'(status(1'b0)), 64'(4'b0011));
        run_frame(1'b0, 1'b0, 600, -1);
        chk("err_cleared_frame_end", 64'(status(1'b0)), 64'(4'b0010));

        // rst mid-frame after 300 pixels
        run_frame(1'b0, 1'b0, 300, -1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midframe_rst_status", 64'(status(1'b0)), 64'(0));
        chk("midframe_rst_mem", 64'({mem_we0, mem_addr0, mem_wdata0}), 64'(0));
        set_in(1'b0, 1'b0, 1'b1, 24'($urandom));
        repeat (3) tick();
        chk("idle_ignores_pixels", 64'(status(1'b0)), 64'(0));
        run_frame(1'b0, 1'b1, 600, -1);
        chk("post_rst_frame_end", 64'(status(1'b0)), 64'(4'b0010));

        repeat (4) tick();
        chk("queue0_drained", 64'(q0.size()), 64'(0));
        chk("queue1_drained", 64'(q1.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
